// File: rtl/pending_encoder.sv
// Accumulates multi-hot request strobes into a pending set and emits one
// binary index per accepted valid/ready transfer, in round-robin order.
module pending_encoder #(
    parameter int unsigned OUTPUT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [(2**OUTPUT_WIDTH)-1:0]  set,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [OUTPUT_WIDTH-1:0]       out,
    output logic [(2**OUTPUT_WIDTH)-1:0]  pending
);

    localparam int unsigned N = 2**OUTPUT_WIDTH;

    logic [OUTPUT_WIDTH-1:0] ptr;
    logic [2*N-1:0]          doubled;
    logic [N-1:0]            rotated;
    logic [OUTPUT_WIDTH-1:0] offset;
    logic                    hit;
    logic [OUTPUT_WIDTH-1:0] grant_idx;
    logic                    load;
    logic                    grant;
    logic [N-1:0]            clear;
    logic [N-1:0]            pending_next;

    // Rotating right by ptr lets a fixed lowest-first priority search start at ptr.
    always_comb begin
        doubled = {pending, pending} >> ptr;
        rotated = doubled[N-1:0];
        offset  = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit && rotated[i]) begin
                hit    = 1'b1;
                offset = i[OUTPUT_WIDTH-1:0];
            end
        end
        grant_idx = ptr + offset;
    end

    always_comb begin
        load  = !out_valid || out_ready;
        grant = load && hit;
        clear = '0;
        if (grant) begin
            clear[grant_idx] = 1'b1;
        end
        // set is applied after clear so a same-cycle re-request stays pending.
        pending_next = (pending & ~clear) | set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            ptr       <= '0;
        end else begin
            pending <= pending_next;
            if (load) begin
                if (grant) begin
                    out       <= grant_idx;
                    out_valid <= 1'b1;
                    ptr       <= grant_idx + OUTPUT_WIDTH'(1);
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pending_encoder.sv
// Bench for pending_encoder: a behavioural round-robin model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pending_encoder;

    localparam int W = 5;
    localparam int N = 32;

    logic          clk;
    logic          reset;
    logic [N-1:0]  set;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out;
    logic [N-1:0]  pending;

    int total;
    int bad;

    pending_encoder #(.OUTPUT_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out       (out),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending set as a bit vector, circular search by modular arithmetic.
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_out;
    int         m_ptr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend  = '0;
            m_valid = 0;
            m_out   = 0;
            m_ptr   = 0;
        end else begin
            bit [N-1:0] clr;
            clr = '0;
            if (!m_valid || out_ready) begin
                int g;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
                if (g >= 0) begin
                    m_out   = g;
                    m_valid = 1;
                    m_ptr   = (g + 1) % N;
                    clr[g]  = 1'b1;
                end else begin
                    m_valid = 0;
                end
            end
            m_pend = (m_pend & ~clr) | set;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("model_out", {27'd0, out}, m_out);
        chk("model_pending", pending, m_pend);
    end

    task automatic expect_out(input string name, input logic v, input int o);
        chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) chk({name, "_out"}, {27'd0, out}, o);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        set = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", {27'd0, out}, 32'd0);
        chk("reset_pending", pending, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request on index 10
        set = 32'h0000_0400;
        @(negedge clk); set = '0;
        chk("single_pend", pending, 32'h0000_0400);
        @(negedge clk);
        expect_out("single_emit", 1'b1, 10);
        chk("single_pend_clr", pending, 32'd0);
        @(negedge clk);
        expect_out("single_drop", 1'b0, 0);

        // Asynchronous reset with a full pending set and a valid output
        set = '1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_pend", pending, 32'hFFFF_FFFF);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        set = '0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_out", {27'd0, out}, 32'd0);
        chk("async_rst_pend", pending, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin sweep from ptr=0
        set = '1;
        @(negedge clk); set = '0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            expect_out("sweep", 1'b1, k);
        end
        @(negedge clk);
        expect_out("sweep_end", 1'b0, 0);

        // Wrap: emit 30, then 31 and 2 together -> 31 first, then 2
        set = 32'h4000_0000;
        @(negedge clk); set = '0;
        @(negedge clk);
        expect_out("wrap30", 1'b1, 30);
        set = 32'h8000_0004;
        @(negedge clk); set = '0;
        @(negedge clk);
        expect_out("wrap31", 1'b1, 31);
        @(negedge clk);
        expect_out("wrap2", 1'b1, 2);
        @(negedge clk);
        expect_out("wrap_end", 1'b0, 0);

        // Backpressure: {3,7} with out_ready low for 5 cycles
        out_ready = 1'b0;
        set = 32'h0000_0088;
        @(negedge clk); set = '0;
        @(negedge clk);
        expect_out("bp_first", 1'b1, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            expect_out("bp_hold", 1'b1, 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expect_out("bp_next", 1'b1, 7);
        @(negedge clk);
        expect_out("bp_end", 1'b0, 0);

        // Collision: re-set 5 as it is granted -> re-emitted after 6 (ptr=8)
        set = 32'h0000_1060;
        @(negedge clk); set = '0;
        @(negedge clk);
        expect_out("coll12", 1'b1, 12);
        set = 32'h0000_0020;
        @(negedge clk); set = '0;
        expect_out("coll5", 1'b1, 5);
        chk("coll_pend", pending, 32'h0000_0060);
        @(negedge clk);
        expect_out("coll6", 1'b1, 6);
        @(negedge clk);
        expect_out("coll5_again", 1'b1, 5);
        @(negedge clk);
        expect_out("coll_end", 1'b0, 0);

        // Coalesce: 9 re-set while already pending -> emitted once
        out_ready = 1'b0;
        set = 32'h0000_0300;
        @(negedge clk); set = '0;
        @(negedge clk);
        expect_out("coal8", 1'b1, 8);
        set = 32'h0000_0200;
        @(negedge clk); set = '0;
        chk("coal_pend", pending, 32'h0000_0200);
        out_ready = 1'b1;
        @(negedge clk);
        expect_out("coal9", 1'b1, 9);
        chk("coal_pend_clr", pending, 32'd0);
        @(negedge clk);
        expect_out("coal_end", 1'b0, 0);

        // Mixed traffic checked by the model only
        for (int k = 0; k < 300; k++) begin
            set = $urandom & $urandom & $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        set = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) @(negedge clk);
        expect_out("drain_end", 1'b0, 0);
        chk("drain_pend", pending, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
